// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame controller: sample layout,
// controller state encoding and index bit reversal.
package fft_pkg;

    localparam int DATA_WIDTH = 50;
    localparam int N_POINTS   = 8;

    typedef struct packed {
        logic [DATA_WIDTH/2-1:0] re;
        logic [DATA_WIDTH/2-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ctrl_state_t;

    // Reverse the low 'bits' bits of idx; the upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < bits) r[b] = idx[bits-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_buf.sv
// N_POINTS x DATA_WIDTH register array with a single-word write port and a
// whole-array parallel load; contents are deliberately not reset.
module fft_sample_buf #(
    parameter int DATA_WIDTH = 50,
    parameter int N_POINTS   = 8,
    parameter int IDX_W      = 3
) (
    input  logic                           clk_i,
    input  logic                           wr_en_i,
    input  logic [IDX_W-1:0]               wr_idx_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic                           load_en_i,
    input  logic [N_POINTS*DATA_WIDTH-1:0] load_data_i,
    output logic [N_POINTS*DATA_WIDTH-1:0] data_o
);

    logic [N_POINTS-1:0][DATA_WIDTH-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem_q <= load_data_i;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign data_o = mem_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Collects a serial sample stream into frames for the FFT core, waits out the
// core latency, captures the core output and replays it as a serial stream.
module fft_frame_ctrl #(
    parameter int DATA_WIDTH   = fft_pkg::DATA_WIDTH,
    parameter int N_POINTS     = fft_pkg::N_POINTS,
    parameter int CORE_LATENCY = 3,
    parameter int BITREV_OUT   = 0,
    localparam int IDX_W       = (N_POINTS > 1) ? $clog2(N_POINTS) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic [DATA_WIDTH-1:0]          s_data_i,
    output logic [N_POINTS*DATA_WIDTH-1:0] core_data_o,
    input  logic [N_POINTS*DATA_WIDTH-1:0] core_data_i,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [DATA_WIDTH-1:0]          m_data_o,
    output logic [IDX_W-1:0]               m_index_o,
    output logic                           m_last_o,
    output logic                           busy_o,
    output logic [15:0]                    frame_cnt_o,
    output logic [1:0]                     state_o
);
    import fft_pkg::*;

    localparam int LAT_EFF = (CORE_LATENCY < 1) ? 1 : CORE_LATENCY;
    localparam int CNT_W   = $clog2(LAT_EFF + 1);

    ctrl_state_t          state_q, state_d;
    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 accept, pop, last_pop, buf_free, capture;
    logic [IDX_W-1:0]     sel_idx;
    logic [N_POINTS-1:0][DATA_WIDTH-1:0] res_words;

    // Handshakes: a beat transfers on a cycle where valid && ready are both high;
    // a source holds valid and its payload until that cycle, and ready never
    // depends combinationally on valid.
    assign accept   = s_valid_i && (state_q == FILL);
    assign pop      = m_valid_q && m_ready_i;
    assign last_pop = pop && (rd_idx_q == IDX_W'(N_POINTS - 1));
    assign buf_free = !m_valid_q || last_pop;

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        lat_cnt_d = lat_cnt_q;
        capture   = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_idx_q == IDX_W'(N_POINTS - 1)) begin
                        wr_idx_d  = '0;
                        lat_cnt_d = CNT_W'(LAT_EFF);
                        state_d   = WAIT;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == CNT_W'(1)) begin
                    lat_cnt_d = '0;
                    if (buf_free) begin
                        capture = 1'b1;
                        state_d = FILL;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (buf_free) begin
                    capture = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // A capture on the cycle the last beat leaves keeps m_valid high seamlessly.
    always_comb begin
        m_valid_d = m_valid_q;
        rd_idx_d  = rd_idx_q;
        if (pop) begin
            if (last_pop) begin
                rd_idx_d  = '0;
                m_valid_d = 1'b0;
            end else begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
            end
        end
        if (capture) begin
            m_valid_d = 1'b1;
            rd_idx_d  = '0;
        end
    end

    assign frame_cnt_d = capture ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            lat_cnt_q   <= '0;
            m_valid_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            lat_cnt_q   <= lat_cnt_d;
            m_valid_q   <= m_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    fft_sample_buf #(.DATA_WIDTH(DATA_WIDTH), .N_POINTS(N_POINTS), .IDX_W(IDX_W)) u_sample_buf (
        .clk_i       (clk_i),
        .wr_en_i     (accept),
        .wr_idx_i    (wr_idx_q),
        .wr_data_i   (s_data_i),
        .load_en_i   (1'b0),
        .load_data_i ('0),
        .data_o      (core_data_o)
    );

    fft_sample_buf #(.DATA_WIDTH(DATA_WIDTH), .N_POINTS(N_POINTS), .IDX_W(IDX_W)) u_result_buf (
        .clk_i       (clk_i),
        .wr_en_i     (1'b0),
        .wr_idx_i    ('0),
        .wr_data_i   ('0),
        .load_en_i   (capture),
        .load_data_i (core_data_i),
        .data_o      (res_words)
    );

    assign sel_idx     = (BITREV_OUT != 0) ? IDX_W'(bitrev(32'(rd_idx_q), IDX_W)) : rd_idx_q;
    assign m_data_o    = res_words[sel_idx];
    assign m_index_o   = sel_idx;
    assign m_valid_o   = m_valid_q;
    assign m_last_o    = m_valid_q && (rd_idx_q == IDX_W'(N_POINTS - 1));
    assign s_ready_o   = (state_q == FILL);
    assign busy_o      = (state_q != FILL) || m_valid_q;
    assign frame_cnt_o = frame_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, and a bit-reversed instance.
module tb_fft_frame_ctrl;
  localparam int DW  = 50;
  localparam int N   = 8;
  localparam int LAT = 3;

  logic clk, rst;
  logic s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [DW-1:0] s_data, m_data;
  logic [2:0] m_index;
  logic [15:0] frame_cnt;
  logic [1:0] state;
  logic [N-1:0][DW-1:0] core_o_w, core_i_w;

  logic s_valid_br, s_ready_br, m_valid_br, m_ready_br, m_last_br, busy_br;
  logic [DW-1:0] s_data_br, m_data_br;
  logic [2:0] m_index_br;
  logic [15:0] frame_cnt_br;
  logic [1:0] state_br;
  logic [N-1:0][DW-1:0] core_o_br, core_i_br;

  fft_frame_ctrl #(.DATA_WIDTH(DW), .N_POINTS(N), .CORE_LATENCY(LAT), .BITREV_OUT(0)) dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .core_data_o(core_o_w), .core_data_i(core_i_w), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_index_o(m_index), .m_last_o(m_last), .busy_o(busy),
    .frame_cnt_o(frame_cnt), .state_o(state)
  );

  fft_frame_ctrl #(.DATA_WIDTH(DW), .N_POINTS(N), .CORE_LATENCY(0), .BITREV_OUT(1)) dut_br (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid_br), .s_ready_o(s_ready_br), .s_data_i(s_data_br),
    .core_data_o(core_o_br), .core_data_i(core_i_br), .m_valid_o(m_valid_br), .m_ready_i(m_ready_br),
    .m_data_o(m_data_br), .m_index_o(m_index_br), .m_last_o(m_last_br), .busy_o(busy_br),
    .frame_cnt_o(frame_cnt_br), .state_o(state_br)
  );

  // Core stand-in: each output word is its input word tagged with the slot number.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      core_i_w[i]  = core_o_w[i] ^ (DW'(i) << 8);
      core_i_br[i] = DW'(i);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of samples being collected, the completed frame
  // waiting for the core, and the queue of result words still to be sent.
  logic [DW-1:0] fill_m[$];
  logic [DW-1:0] held_m[N];
  logic [DW-1:0] out_m[$];
  bit            pending_m = 0;
  int            done_cyc_m = 0;
  int            cyc_m = 0;
  logic [15:0]   fcnt_m = 0;

  task automatic model_advance();
    bit free, elig;
    logic [DW-1:0] junk;
    if (rst) begin
      fill_m.delete();
      out_m.delete();
      pending_m = 0;
      fcnt_m = 0;
    end else begin
      free = (out_m.size() == 0) || (out_m.size() == 1 && m_ready);
      elig = pending_m && (cyc_m >= done_cyc_m + LAT);
      if (out_m.size() != 0 && m_ready) junk = out_m.pop_front();
      if (elig && free) begin
        for (int i = 0; i < N; i++) out_m.push_back(held_m[i] ^ (DW'(i) << 8));
        fcnt_m = fcnt_m + 16'd1;
        pending_m = 0;
      end else if (!pending_m && s_valid) begin
        fill_m.push_back(s_data);
        if (fill_m.size() == N) begin
          for (int i = 0; i < N; i++) held_m[i] = fill_m[i];
          fill_m.delete();
          pending_m = 1;
          done_cyc_m = cyc_m;
        end
      end
    end
    cyc_m++;
  endtask

  task automatic model_compare();
    logic [1:0] exp_state;
    if (!pending_m) exp_state = 2'd0;
    else if (cyc_m <= done_cyc_m + LAT) exp_state = 2'd1;
    else exp_state = 2'd2;
    check("s_ready", s_ready, !pending_m);
    check("m_valid", m_valid, out_m.size() != 0);
    check("busy", busy, pending_m || out_m.size() != 0);
    check("frame_cnt", frame_cnt, fcnt_m);
    check("state", state, exp_state);
    if (out_m.size() != 0) begin
      check("m_data", m_data, out_m[0]);
      check("m_index", m_index, N - out_m.size());
      check("m_last", m_last, out_m.size() == 1);
    end else begin
      check("m_last_idle", m_last, 0);
    end
    if (pending_m) begin
      for (int i = 0; i < N; i++) check("core_data_o", core_o_w[i], held_m[i]);
    end
  endtask

  // One clock: predict the edge from the current inputs, pass the edge, compare.
  task automatic step();
    model_advance();
    @(negedge clk);
    model_compare();
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[DW-1:0];
  endfunction

  logic [DW-1:0] d[N];
  int lat;
  int stall_left;
  int br_exp[N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    s_valid_br = 1'b0; s_data_br = '0; m_ready_br = 1'b0;
    @(negedge clk);
    step();
    step();
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    step();

    // Frame 0x1..0x8 back to back, sink always ready.
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b1; s_data = DW'(k + 1);
      step();
    end
    s_valid = 1'b0;
    lat = N;
    while (!m_valid && lat < 40) begin
      step();
      lat++;
    end
    // 8 accept edges + 3 wait edges; the first result is shown in cycle 12.
    check("first_result_edges", lat, 11);
    for (int k = 0; k < N; k++) begin
      check("t1_data", m_data, DW'(k + 1) ^ (DW'(k) << 8));
      check("t1_index", m_index, k);
      check("t1_last", m_last, k == N - 1);
      step();
    end
    check("t1_drained", m_valid, 0);
    check("t1_frame_cnt", frame_cnt, 1);

    // Offer a sample while the frame waits on the core.
    for (int k = 0; k < N; k++) begin
      d[k] = rnd_word();
      s_valid = 1'b1; s_data = d[k];
      step();
    end
    s_data = DW'(50'hDEAD);
    for (int k = 0; k < 2; k++) begin
      step();
      check("wait_s_ready", s_ready, 0);
      check("wait_core0", core_o_w[0], d[0]);
      check("wait_core7", core_o_w[N-1], d[N-1]);
    end
    s_valid = 1'b0;
    repeat (20) step();
    check("t2_frame_cnt", frame_cnt, 2);

    // Sink stalls while a second frame finishes.
    m_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) begin
        s_valid = 1'b1; s_data = rnd_word();
        step();
      end
      s_valid = 1'b0;
      repeat (4 + f) step();
    end
    check("hold_state", state, 2);
    check("hold_busy", busy, 1);
    check("hold_s_ready", s_ready, 0);
    m_ready = 1'b1;
    repeat (30) step();
    check("hold_frame_cnt", frame_cnt, 4);
    check("hold_drained", m_valid, 0);

    // Reset part way into a frame, then a fresh frame.
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = DW'(50'h3300 + k);
      step();
    end
    s_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_m_valid", m_valid, 0);
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b1; s_data = DW'(50'h100 + k);
      step();
    end
    s_valid = 1'b0;
    lat = N;
    while (!m_valid && lat < 40) begin
      step();
      lat++;
    end
    check("abort_latency", lat, 11);
    check("abort_first", m_data, DW'(50'h100));
    repeat (10) step();
    check("abort_frame_cnt", frame_cnt, 1);

    // Counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    fcnt_m = 16'hFFFF;
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b1; s_data = rnd_word();
      step();
    end
    s_valid = 1'b0;
    repeat (12) step();
    check("wrap_frame_cnt", frame_cnt, 0);

    // Bit-reversed instance with zero core latency.
    m_ready_br = 1'b1;
    for (int k = 0; k < N; k++) begin
      s_valid_br = 1'b1; s_data_br = rnd_word();
      step();
    end
    s_valid_br = 1'b0;
    lat = N;
    while (!m_valid_br && lat < 40) begin
      step();
      lat++;
    end
    check("br_latency", lat, 9);
    for (int k = 0; k < N; k++) begin
      check("br_data", m_data_br, br_exp[k]);
      check("br_index", m_index_br, br_exp[k]);
      check("br_last", m_last_br, k == N - 1);
      step();
    end
    check("br_drained", m_valid_br, 0);
    check("br_frame_cnt", frame_cnt_br, 1);

    // Random traffic with stalls and occasional resets.
    stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 99) < 60);
      s_data = rnd_word();
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = ($urandom_range(0, 99) < 75);
        if ($urandom_range(0, 49) == 0) stall_left = $urandom_range(5, 25);
      end
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
